johnson_monitor: RTL
====================

JOHNSON_MONITOR -- requirements
Module: johnson_monitor

Interface
REQ-001 Parameter: LOCK_N, default 3, range 1..15; consecutive correct successions required to declare lock.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; asserting it (0) clears all state immediately; release is taken on clk.
REQ-004 en  input  1  sample enable; when 1, q_in is sampled and checked at the rising edge.
REQ-005 q_in  input  4  4-bit Johnson counter state from the upstream counter.
REQ-006 clr  input  1  synchronous clear of err_sticky and err_cnt.
REQ-007 phase  output  8  registered one-hot phase index of the last sampled code; 0 when that code is illegal.
REQ-008 legal  output  1  registered: last sampled code is one of the 8 legal codes.
REQ-009 locked  output  1  monitor is in state LOCKED.
REQ-010 err_pulse  output  1  one-cycle pulse on a sequence error while LOCKED.
REQ-011 err_sticky  output  1  set by err_pulse, held until clr or reset.
REQ-012 err_cnt  output  8  error count, saturating.
REQ-013 rev_cnt  output  8  completed-revolution count, wraps modulo 256.
REQ-014 rev_pulse  output  1  one-cycle pulse per completed revolution.

Function
REQ-015 The legal sequence, phases 0..7, SHALL be 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000, then back to 0000; phase p sets phase[p].
REQ-016 The other 8 codes SHALL be illegal; for them, legal=0 and phase=0.
REQ-017 Each enabled edge SHALL register q_in into q_r, plus a q_r_valid flag, and update phase and legal; latency is 1 cycle from sample to output.
REQ-018 A succession SHALL be correct when q_r_valid=1, q_in is legal, and q_in equals the successor of q_r; a repeated value, skipped phase or reversed step is incorrect.
REQ-019 States: UNLOCKED, LOCKING, LOCKED. A 4-bit match counter, mcnt, counts correct successions.
REQ-020 UNLOCKED: a legal sample SHALL move to LOCKING with mcnt=0; an illegal sample keeps UNLOCKED.
REQ-021 LOCKING: a correct succession SHALL increment mcnt, and on reaching LOCK_N go to LOCKED.
REQ-022 LOCKING: an incorrect but legal sample SHALL restart LOCKING with mcnt=0; an illegal sample SHALL go to UNLOCKED.
REQ-023 LOCKED: a correct succession SHALL stay LOCKED.
REQ-024 LOCKED: an incorrect succession SHALL assert err_pulse for one cycle and set err_sticky.
REQ-025 The same LOCKED error SHALL increment err_cnt, saturating at 255, and move to UNLOCKED, or to LOCKING with mcnt=0 if the sample is legal.
REQ-026 Mismatches in UNLOCKED or LOCKING SHALL NOT raise errors.
REQ-027 In LOCKED, a correct 1000->0000 succession SHALL assert rev_pulse for one cycle and increment rev_cnt; 255 SHALL wrap to 0.
REQ-028 en=0 SHALL hold all registers except err_pulse and rev_pulse, which are 0.
REQ-029 clr=1 SHALL clear err_sticky and err_cnt, independent of en.
REQ-030 clr and a new error in the same cycle: the error wins, giving err_sticky=1 and err_cnt=1.
REQ-031 rev_cnt SHALL be unaffected by clr.

Reset
REQ-032 reset=0 SHALL asynchronously force UNLOCKED and q_r_valid=0.
REQ-033 reset=0 SHALL asynchronously set q_r=0000, mcnt=0 and all outputs to 0, including mid-operation.
REQ-034 After reset release, the first enabled sample SHALL NOT be checked for succession (q_r_valid=0).

Verification
REQ-035 Release reset, en=1, drive the legal sequence from 0000 -> legal=1 and phase tracks 00000001, 00000010, ...; locked=1 in the cycle after the 4th sample (LOCK_N=3).
REQ-036 While locked, run 2 full revolutions -> rev_pulse twice, on each 1000->0000, with rev_cnt=2; after 256 revolutions, rev_cnt=0.
REQ-037 Locked at 0011, drive 0101 -> err_pulse=1 for one cycle, err_sticky=1, err_cnt=1, locked=0, phase=0, legal=0.
REQ-038 Locked at 0001, drive 0111 (skip); relock, then repeat 1111 twice -> two errors, err_cnt=2; clr in the same cycle as a third error -> err_sticky=1, err_cnt=1.
REQ-039 Hold en=0 for 5 cycles mid-sequence, then resume with the correct successor -> no error, locked stays 1.
REQ-040 Pull reset low mid-LOCKED between clock edges -> all outputs 0 immediately; after release, 4 correct samples relock.

Source files
------------

// File: rtl/johnson_monitor.sv
// johnson_monitor
// Watches a 4-bit Johnson counter and checks that every enabled sample is the
// legal successor of the previous one. Declares lock after LOCK_N consecutive
// correct successions, flags sequence errors while locked, and counts
// completed revolutions (1000 -> 0000 while locked).
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset (release taken on clk)
//   en         sample enable for q_in
//   q_in       4-bit Johnson code from the upstream counter
//   clr        synchronous clear of err_sticky / err_cnt (independent of en)
//   phase      registered one-hot phase of the last sample, 0 if illegal
//   legal      registered: last sample was one of the 8 legal codes
//   locked     monitor is in LOCKED
//   err_pulse  one-cycle pulse on a sequence error while LOCKED
//   err_sticky set by an error, held until clr or reset
//   err_cnt    saturating error count
//   rev_cnt    completed-revolution count, wraps modulo 256
//   rev_pulse  one-cycle pulse per completed revolution
module johnson_monitor #(
   parameter int LOCK_N = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic [3:0] q_in,
   input  logic       clr,
   output logic [7:0] phase,
   output logic       legal,
   output logic       locked,
   output logic       err_pulse,
   output logic       err_sticky,
   output logic [7:0] err_cnt,
   output logic [7:0] rev_cnt,
   output logic       rev_pulse
);

   typedef enum logic [1:0] {UNLOCKED, LOCKING, LOCKED} state_t;

   localparam logic [3:0] LOCK_V = 4'(LOCK_N);

   state_t     state, state_n;
   logic [3:0] mcnt, mcnt_n;
   logic [3:0] q_r;
   logic       q_r_valid;

   logic [7:0] in_onehot;
   logic       in_legal;
   logic [3:0] succ;
   logic       correct;
   logic       err_hit, rev_hit;

   // Decode the incoming code into its phase
   always_comb begin
      in_legal  = 1'b1;
      in_onehot = 8'h00;
      case (q_in)
         4'b0000: in_onehot = 8'h01;
         4'b0001: in_onehot = 8'h02;
         4'b0011: in_onehot = 8'h04;
         4'b0111: in_onehot = 8'h08;
         4'b1111: in_onehot = 8'h10;
         4'b1110: in_onehot = 8'h20;
         4'b1100: in_onehot = 8'h40;
         4'b1000: in_onehot = 8'h80;
         default: in_legal  = 1'b0;
      endcase
   end

   // Johnson step: shift left, feed back inverted MSB. For an illegal q_r this
   // yields another illegal code, so it can never match a legal q_in.
   assign succ    = {q_r[2:0], ~q_r[3]};
   assign correct = q_r_valid & in_legal & (q_in == succ);

   always_comb begin
      state_n = state;
      mcnt_n  = mcnt;
      err_hit = 1'b0;
      rev_hit = 1'b0;
      if (en) begin
         case (state)
            UNLOCKED: begin
               if (in_legal) begin
                  state_n = LOCKING;
                  mcnt_n  = 4'd0;
               end
            end
            LOCKING: begin
               if (correct) begin
                  mcnt_n = mcnt + 4'd1;
                  if (mcnt + 4'd1 == LOCK_V) begin
                     state_n = LOCKED;
                     mcnt_n  = 4'd0;
                  end
               end else if (in_legal) begin
                  mcnt_n = 4'd0;
               end else begin
                  state_n = UNLOCKED;
                  mcnt_n  = 4'd0;
               end
            end
            LOCKED: begin
               if (correct) begin
                  rev_hit = (q_r == 4'b1000);
               end else begin
                  err_hit = 1'b1;
                  mcnt_n  = 4'd0;
                  state_n = in_legal ? LOCKING : UNLOCKED;
               end
            end
            default: begin
               state_n = UNLOCKED;
               mcnt_n  = 4'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= UNLOCKED;
         mcnt       <= 4'd0;
         q_r        <= 4'd0;
         q_r_valid  <= 1'b0;
         phase      <= 8'h00;
         legal      <= 1'b0;
         err_pulse  <= 1'b0;
         err_sticky <= 1'b0;
         err_cnt    <= 8'h00;
         rev_cnt    <= 8'h00;
         rev_pulse  <= 1'b0;
      end else begin
         state     <= state_n;
         mcnt      <= mcnt_n;
         err_pulse <= err_hit;
         rev_pulse <= rev_hit;
         if (en) begin
            q_r       <= q_in;
            q_r_valid <= 1'b1;
            phase     <= in_onehot;
            legal     <= in_legal;
         end
         // A new error outranks a same-cycle clear
         if (err_hit) begin
            err_sticky <= 1'b1;
            if (clr)                  err_cnt <= 8'd1;
            else if (err_cnt != 8'hff) err_cnt <= err_cnt + 8'd1;
         end else if (clr) begin
            err_sticky <= 1'b0;
            err_cnt    <= 8'h00;
         end
         if (rev_hit) rev_cnt <= rev_cnt + 8'd1;
      end
   end

   assign locked = (state == LOCKED);

endmodule
